// File: rtl/arr_feature_loader.sv
// Streaming feature loader: conditions sign-magnitude samples into a shadow frame,
// launches them as the core's parallel x vector and sequences the core restart.
module arr_feature_loader #(
   parameter int                 BITSIZE      = 16,
   parameter int                 N_FEAT       = 10,
   parameter int                 START_PULSE  = 2,
   parameter int                 CORE_TIMEOUT = 255,
   parameter logic [BITSIZE-2:0] MAX_MAG      = 15'h7FFF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [BITSIZE-1:0]        s_data,
   input  logic                      s_last,
   output logic [BITSIZE*N_FEAT-1:0] x_out,
   output logic                      core_reset,
   input  logic                      core_done,
   output logic                      done_pulse,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      timeout_err,
   output logic [15:0]               frames_launched
);
   localparam int CW = $clog2(N_FEAT + 1);
   localparam int PW = $clog2(START_PULSE + 1);
   localparam int TW = $clog2(CORE_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

   state_t                              state_q, state_n;
   logic [N_FEAT-1:0][BITSIZE-1:0]      shadow;
   logic [CW-1:0]                       fill_cnt;
   logic                                shadow_full;
   logic [PW-1:0]                       pulse_cnt;
   logic [TW-1:0]                       run_cnt;
   logic                                done_prev;
   logic [BITSIZE-1:0]                  cond_data;
   logic                                accept, load, done_hit, to_hit;

   assign s_ready    = !shadow_full;
   assign accept     = s_valid && s_ready;
   assign core_reset = (state_q != RUN);
   assign busy       = (state_q != IDLE);

   // Negative zero folds to +0; oversize magnitudes saturate, sign preserved.
   always_comb begin
      cond_data = s_data;
      if (s_data[BITSIZE-2:0] > MAX_MAG)
         cond_data = {s_data[BITSIZE-1], MAX_MAG};
      if (s_data[BITSIZE-2:0] == '0)
         cond_data = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow      <= '0;
         fill_cnt    <= '0;
         shadow_full <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (load)
            shadow_full <= 1'b0;
         if (accept) begin
            if (fill_cnt == CW'(N_FEAT - 1)) begin
               fill_cnt <= '0;
               if (s_last) begin
                  shadow[fill_cnt] <= cond_data;
                  shadow_full      <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end else if (s_last) begin
               fill_cnt  <= '0;
               frame_err <= 1'b1;
            end else begin
               shadow[fill_cnt] <= cond_data;
               fill_cnt         <= fill_cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      load     = 1'b0;
      done_hit = 1'b0;
      to_hit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (shadow_full) begin
               load    = 1'b1;
               state_n = LAUNCH;
            end
         end
         LAUNCH: begin
            if (pulse_cnt == '0) state_n = RUN;
         end
         RUN: begin
            // Done has priority over a timeout landing on the same edge.
            if (core_done && !done_prev) begin
               done_hit = 1'b1;
               state_n  = IDLE;
            end else if (run_cnt == TW'(CORE_TIMEOUT - 1)) begin
               to_hit  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_out           <= '0;
         frames_launched <= '0;
         pulse_cnt       <= '0;
         run_cnt         <= '0;
         done_prev       <= 1'b1;
         done_pulse      <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         done_pulse  <= done_hit;
         timeout_err <= to_hit;
         // Held high while the core is in restart so a stale done level is not an edge.
         done_prev   <= core_reset ? 1'b1 : core_done;
         if (load) begin
            x_out           <= shadow;
            frames_launched <= frames_launched + 16'd1;
            pulse_cnt       <= PW'(START_PULSE - 1);
         end else if (state_q == LAUNCH && pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PW'(1);
         end
         if (state_q == RUN) run_cnt <= run_cnt + TW'(1);
         else                run_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_arr_feature_loader.sv
// Directed bench for arr_feature_loader: stimulus pushes expected launch/done/error
// events into a queue, a negedge monitor pops and compares them as the DUT emits them.
module tb_arr_feature_loader;
   localparam int K_LAUNCH = 0, K_DONE = 1, K_FERR = 2, K_TOUT = 3;

   typedef struct {
      int           kind;
      logic [159:0] x;
      logic [15:0]  fl;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [15:0]  s_data = '0;
   logic         s_last = 1'b0;
   logic [159:0] x_out;
   logic         core_reset;
   logic         core_done = 1'b0;
   logic         done_pulse, busy, frame_err, timeout_err;
   logic [15:0]  frames_launched;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic busy_q = 1'b0;

   arr_feature_loader #(
      .BITSIZE(16), .N_FEAT(10), .START_PULSE(2), .CORE_TIMEOUT(32), .MAX_MAG(15'h1000)
   ) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .x_out(x_out), .core_reset(core_reset), .core_done(core_done),
      .done_pulse(done_pulse), .busy(busy), .frame_err(frame_err),
      .timeout_err(timeout_err), .frames_launched(frames_launched)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [159:0] x, input logic [15:0] fl);
      exp_t e;
      e.kind = kind; e.x = x; e.fl = fl;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL unexpected_event got=%0d want=none", kind);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 160'(kind), 160'(e.kind));
         if (e.kind == K_LAUNCH && kind == K_LAUNCH) begin
            chk("launch_x", x_out, e.x);
            chk("launch_count", 160'(frames_launched), 160'(e.fl));
         end
         if (e.kind == K_DONE && kind == K_DONE)
            chk("done_count", 160'(frames_launched), 160'(e.fl));
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (busy && !busy_q) observe(K_LAUNCH);
         if (done_pulse)      observe(K_DONE);
         if (frame_err)       observe(K_FERR);
         if (timeout_err)     observe(K_TOUT);
      end
      busy_q = busy;
   end

   function automatic logic [159:0] ramp(input logic [15:0] base);
      logic [159:0] v;
      v = '0;
      for (int i = 0; i < 10; i++) v[16*i +: 16] = base + 16'(i);
      return v;
   endfunction

   task automatic send(input logic [15:0] d, input logic l);
      int n;
      n = 0;
      s_valid = 1'b1; s_data = d; s_last = l;
      while (!s_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("send_ready", 160'(s_ready), 160'(1));
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input int n, input int last_idx);
      for (int i = 0; i < n; i++) send(base + 16'(i), i == last_idx);
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (core_reset && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("run_entry", 160'(core_reset), 160'(0));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done_pulse && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("done_seen", 160'(done_pulse), 160'(1));
      chk("done_idle", 160'(busy), 160'(0));
      chk("done_core_reset", 160'(core_reset), 160'(1));
   endtask

   task automatic run_to_done(input logic [15:0] fl, input int dly);
      core_done = 1'b0;
      wait_run();
      repeat (dly) @(posedge clk);
      #1;
      push(K_DONE, '0, fl);
      core_done = 1'b1;
      wait_done();
      core_done = 1'b0;
   endtask

   logic [15:0]  cin  [10] = '{16'h8000, 16'hFFFF, 16'h1000, 16'h9001, 16'h0FFF,
                               16'h7FFF, 16'h0005, 16'h8003, 16'h1001, 16'h0000};
   logic [15:0]  cexp [10] = '{16'h0000, 16'h9000, 16'h1000, 16'h9000, 16'h0FFF,
                               16'h1000, 16'h0005, 16'h8003, 16'h1000, 16'h0000};

   initial begin
      logic [159:0] cvec;
      int n;

      // reset values
      #3;
      chk("rst_s_ready", 160'(s_ready), 160'(1));
      chk("rst_x_out", x_out, '0);
      chk("rst_core_reset", 160'(core_reset), 160'(1));
      chk("rst_busy", 160'(busy), 160'(0));
      chk("rst_pulses", 160'({done_pulse, frame_err, timeout_err}), 160'(0));
      chk("rst_count", 160'(frames_launched), 160'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // single frame with launch timing
      push(K_LAUNCH, ramp(16'h0001), 16'd1);
      send_frame(16'h0001, 10, 9);
      chk("commit_backpressure", 160'(s_ready), 160'(0));
      @(posedge clk); #1;
      chk("load_ready", 160'(s_ready), 160'(1));
      chk("load_core_reset", 160'(core_reset), 160'(1));
      chk("x0", 160'(x_out[15:0]), 160'(16'h0001));
      chk("x9", 160'(x_out[159:144]), 160'(16'h000A));
      @(posedge clk); #1;
      chk("launch_hold", 160'(core_reset), 160'(1));
      @(posedge clk); #1;
      chk("launch_release", 160'(core_reset), 160'(0));
      run_to_done(16'd1, 20);

      // conditioning
      cvec = '0;
      for (int i = 0; i < 10; i++) cvec[16*i +: 16] = cexp[i];
      push(K_LAUNCH, cvec, 16'd2);
      for (int i = 0; i < 10; i++) send(cin[i], i == 9);
      run_to_done(16'd2, 3);

      // framing errors, then a clean frame
      push(K_FERR, '0, '0);
      send_frame(16'h0010, 4, 3);
      push(K_FERR, '0, '0);
      send_frame(16'h0010, 10, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("ferr_no_launch", 160'(busy), 160'(0));
      chk("ferr_count", 160'(frames_launched), 160'(2));
      push(K_LAUNCH, ramp(16'h0020), 16'd3);
      send_frame(16'h0020, 10, 9);
      run_to_done(16'd3, 3);

      // overlap and backpressure
      push(K_LAUNCH, ramp(16'h0200), 16'd4);
      send_frame(16'h0200, 10, 9);
      wait_run();
      push(K_DONE, '0, 16'd4);
      push(K_LAUNCH, ramp(16'h0100), 16'd5);
      send_frame(16'h0100, 10, 9);
      chk("ovl_ready_low", 160'(s_ready), 160'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("ovl_ready_held", 160'(s_ready), 160'(0));
      chk("ovl_x_stable", 160'(x_out[15:0]), 160'(16'h0200));
      core_done = 1'b1;
      wait_done();
      chk("ovl_x_at_done", 160'(x_out[15:0]), 160'(16'h0200));
      core_done = 1'b0;
      @(posedge clk); #1;
      chk("ovl_x_next", 160'(x_out[15:0]), 160'(16'h0100));
      chk("ovl_count", 160'(frames_launched), 160'(5));
      run_to_done(16'd5, 3);

      // timeout with a stale done level
      core_done = 1'b1;
      push(K_LAUNCH, ramp(16'h0300), 16'd6);
      push(K_TOUT, '0, '0);
      send_frame(16'h0300, 10, 9);
      wait_run();
      n = 0;
      while (!timeout_err && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("timeout_cycles", 160'(n), 160'(32));
      chk("timeout_idle", 160'(busy), 160'(0));
      core_done = 1'b0;

      // reset mid-run with a half-filled shadow buffer
      push(K_LAUNCH, ramp(16'h0400), 16'd7);
      send_frame(16'h0400, 10, 9);
      wait_run();
      send_frame(16'h0500, 5, -1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_x", x_out, '0);
      chk("mid_rst_core_reset", 160'(core_reset), 160'(1));
      chk("mid_rst_ready", 160'(s_ready), 160'(1));
      chk("mid_rst_count", 160'(frames_launched), 160'(0));
      @(posedge clk); #1 reset = 1'b1;
      core_done = 1'b1;
      n = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done_pulse) n++;
      end
      chk("mid_rst_no_done", 160'(n), 160'(0));
      push(K_LAUNCH, ramp(16'h0600), 16'd1);
      send_frame(16'h0600, 10, 9);
      run_to_done(16'd1, 3);

      repeat (2) @(posedge clk);
      chk("queue_drained", 160'(exp_q.size()), 160'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
